// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter sharing one single-port memory
//                between an instruction-fetch port (if_*) and a data port
//                (dm_*). Each access holds the memory for WAIT_STATES+1
//                cycles, then spends one RESP cycle acknowledging the owner.
//                The data port has priority. A defer counter forces a fetch
//                grant once fetch has lost MAX_DEFER consecutive arbitrations.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            clock, synchronous active-high reset
//    if_req/if_addr      fetch request and address (held until if_ack)
//    if_rdata/if_ack     fetch read data and one-cycle completion pulse
//    dm_req/dm_we/
//    dm_addr/dm_wdata    data request, direction, address, write data
//    dm_rdata/dm_ack     data read result and one-cycle completion pulse
//    mem_en/mem_we/
//    mem_addr/mem_wdata  shared memory command (valid only during ACCESS)
//    mem_rdata           shared memory read data
//    stall_f/stall_m     pipeline stalls for the fetch and memory stages
//    busy                high whenever the arbiter is not idle
// ============================================================================
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 2,
    parameter int MAX_DEFER   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_f,
    output logic          stall_m,
    output logic          busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic c_OWN_IF = 1'b0;
    localparam logic c_OWN_DM = 1'b1;

    // Counter widths are kept at least one bit so zero-valued parameters
    // still produce legal vectors.
    localparam int c_WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int c_DCW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;

    localparam logic [c_WCW-1:0] c_WAIT_LOAD = c_WCW'(WAIT_STATES);
    localparam logic [c_WCW-1:0] c_WAIT_ONE  = c_WCW'(1);
    localparam logic [c_DCW-1:0] c_DEFER_MAX = c_DCW'(MAX_DEFER);
    localparam logic [c_DCW-1:0] c_DEFER_ONE = c_DCW'(1);

    logic [1:0]       r_state;
    logic             r_owner;
    logic [c_WCW-1:0] r_waitCnt;
    logic [c_DCW-1:0] r_deferCnt;
    logic [DW-1:0]    r_ifRdata;
    logic [DW-1:0]    r_dmRdata;

    logic w_arbitrate;
    logic w_ifElig;
    logic w_dmElig;
    logic w_grant;
    logic w_grantIf;
    logic w_inAccess;
    logic w_dmOwnsAccess;

    // Arbitration happens in IDLE and in RESP; in RESP the port being
    // acknowledged is still holding req, so it must not win again.
    assign w_arbitrate = (r_state == c_IDLE) || (r_state == c_RESP);
    assign w_ifElig    = if_req && !((r_state == c_RESP) && (r_owner == c_OWN_IF));
    assign w_dmElig    = dm_req && !((r_state == c_RESP) && (r_owner == c_OWN_DM));
    assign w_grant     = w_arbitrate && (w_ifElig || w_dmElig);
    assign w_grantIf   = w_ifElig && (!w_dmElig || (r_deferCnt == c_DEFER_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_owner    <= c_OWN_IF;
            r_waitCnt  <= '0;
            r_deferCnt <= '0;
            r_ifRdata  <= '0;
            r_dmRdata  <= '0;
        end else begin
            case (r_state)
                c_ACCESS: begin
                    if (r_waitCnt == '0) begin
                        r_state <= c_RESP;
                        // Last memory cycle: capture the read result.
                        if (r_owner == c_OWN_IF) begin
                            r_ifRdata <= mem_rdata;
                        end else if (!dm_we) begin
                            r_dmRdata <= mem_rdata;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt - c_WAIT_ONE;
                    end
                end
                default: begin
                    // IDLE and RESP both arbitrate.
                    if (w_grant) begin
                        r_state   <= c_ACCESS;
                        r_owner   <= w_grantIf ? c_OWN_IF : c_OWN_DM;
                        r_waitCnt <= c_WAIT_LOAD;
                    end else begin
                        r_state <= c_IDLE;
                    end

                    if (!if_req || (w_grant && w_grantIf)) begin
                        r_deferCnt <= '0;
                    end else if (w_grant && (r_deferCnt != c_DEFER_MAX)) begin
                        // Fetch wanted the memory but data was granted.
                        r_deferCnt <= r_deferCnt + c_DEFER_ONE;
                    end
                end
            endcase
        end
    end

    assign w_inAccess     = (r_state == c_ACCESS);
    assign w_dmOwnsAccess = w_inAccess && (r_owner == c_OWN_DM);

    assign mem_en    = w_inAccess;
    assign mem_we    = w_dmOwnsAccess && dm_we;
    assign mem_addr  = !w_inAccess ? '0 : (w_dmOwnsAccess ? dm_addr : if_addr);
    assign mem_wdata = w_dmOwnsAccess ? dm_wdata : '0;

    assign if_ack   = (r_state == c_RESP) && (r_owner == c_OWN_IF);
    assign dm_ack   = (r_state == c_RESP) && (r_owner == c_OWN_DM);
    assign if_rdata = r_ifRdata;
    assign dm_rdata = r_dmRdata;

    assign stall_f = if_req && !if_ack;
    assign stall_m = dm_req && !dm_ack;
    assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A timeline reference
//                model (grant cycle + elapsed cycles) predicts every output
//                each cycle while randomized requesters and resets drive the
//                design. A few directed transactions check absolute latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int WAIT_STATES = 2;
    localparam int MAX_DEFER   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_f;
    logic          stall_m;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .WAIT_STATES (WAIT_STATES),
        .MAX_DEFER   (MAX_DEFER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .busy      (busy)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: a transaction is described by the cycle it was
    // granted in; ACCESS spans grant+1 .. grant+WAIT_STATES+1 and the
    // acknowledge lands at grant+WAIT_STATES+2.
    bit            mActive;
    int            mGrant;
    bit            mOwnerDm;
    int            mDefer;
    logic [DW-1:0] mIfData;
    logic [DW-1:0] mDmData;
    int            cyc;

    bit ifDone;
    bit dmDone;
    bit dutIfAck;
    bit dutDmAck;
    bit dutMemWe;

    int ifPct;
    int dmPct;
    int rePct;
    int wePct;
    int rstPct;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            nPass++;
        end
    endtask

    // Check one cycle's outputs at the falling edge, then advance the model
    // across the next rising edge.
    task automatic stepCycle();
        int age;
        bit inAcc;
        bit inResp;
        bit ifE;
        bit dmE;
        bit gIf;
        @(negedge clk);
        age    = cyc - mGrant;
        inAcc  = mActive && (age >= 1) && (age <= WAIT_STATES + 1);
        inResp = mActive && (age == WAIT_STATES + 2);

        checkVal("mem_en",    64'(mem_en),    64'(inAcc));
        checkVal("mem_we",    64'(mem_we),    64'(inAcc && mOwnerDm && dm_we));
        checkVal("mem_addr",  64'(mem_addr),  inAcc ? (mOwnerDm ? 64'(dm_addr) : 64'(if_addr)) : 64'd0);
        checkVal("mem_wdata", 64'(mem_wdata), (inAcc && mOwnerDm) ? 64'(dm_wdata) : 64'd0);
        checkVal("if_ack",    64'(if_ack),    64'(inResp && !mOwnerDm));
        checkVal("dm_ack",    64'(dm_ack),    64'(inResp && mOwnerDm));
        checkVal("if_rdata",  64'(if_rdata),  64'(mIfData));
        checkVal("dm_rdata",  64'(dm_rdata),  64'(mDmData));
        checkVal("busy",      64'(busy),      64'(inAcc || inResp));
        checkVal("stall_f",   64'(stall_f),   64'(if_req && !(inResp && !mOwnerDm)));
        checkVal("stall_m",   64'(stall_m),   64'(dm_req && !(inResp && mOwnerDm)));

        ifDone   = inResp && !mOwnerDm;
        dmDone   = inResp && mOwnerDm;
        dutIfAck = if_ack;
        dutDmAck = dm_ack;
        dutMemWe = mem_we;

        if (rst) begin
            mActive = 1'b0;
            mDefer  = 0;
            mIfData = '0;
            mDmData = '0;
        end else begin
            if (inAcc && (age == WAIT_STATES + 1)) begin
                if (!mOwnerDm) begin
                    mIfData = mem_rdata;
                end else if (!dm_we) begin
                    mDmData = mem_rdata;
                end
            end
            if (!mActive || inResp) begin
                ifE = if_req && !(inResp && !mOwnerDm);
                dmE = dm_req && !(inResp && mOwnerDm);
                if (ifE || dmE) begin
                    gIf = ifE && (!dmE || (mDefer == MAX_DEFER));
                    if (!if_req || gIf) begin
                        mDefer = 0;
                    end else if (mDefer < MAX_DEFER) begin
                        mDefer = mDefer + 1;
                    end
                    mActive  = 1'b1;
                    mGrant   = cyc;
                    mOwnerDm = !gIf;
                end else begin
                    mActive = 1'b0;
                    if (!if_req) begin
                        mDefer = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Randomized requesters that respect the hold-until-ack protocol.
    task automatic driveRandom();
        mem_rdata = $urandom;
        rst = ($urandom_range(0, 99) < rstPct);
        if (!if_req) begin
            if ($urandom_range(0, 99) < ifPct) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
        end else if (ifDone) begin
            if ($urandom_range(0, 99) < rePct) begin
                if_addr = $urandom;
            end else begin
                if_req = 1'b0;
            end
        end
        if (!dm_req) begin
            if ($urandom_range(0, 99) < dmPct) begin
                dm_req   = 1'b1;
                dm_we    = ($urandom_range(0, 99) < wePct);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
        end else if (dmDone) begin
            if ($urandom_range(0, 99) < rePct) begin
                dm_we    = ($urandom_range(0, 99) < wePct);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end else begin
                dm_req = 1'b0;
            end
        end
    endtask

    int phaseCfg [4][5] = '{
        '{30,  30,  50,  50, 0},
        '{100, 100, 100, 30, 0},
        '{60,  60,  70,  50, 3},
        '{10,  90,  80,  70, 2}
    };

    initial begin
        int lat;
        int weCycles;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mActive   = 1'b0;
        mGrant    = 0;
        mOwnerDm  = 1'b0;
        mDefer    = 0;
        mIfData   = '0;
        mDmData   = '0;
        cyc       = 0;
        ifDone    = 1'b0;
        dmDone    = 1'b0;

        @(posedge clk);
        #1;
        stepCycle();
        rst = 1'b0;

        // Single fetch: ack expected WAIT_STATES+2 cycles after the request.
        if_req    = 1'b1;
        if_addr   = 32'h10;
        mem_rdata = 32'hDEADBEEF;
        lat       = 0;
        do begin
            stepCycle();
            lat++;
        end while (!dutIfAck && lat < 20);
        checkVal("fetch_latency", 64'(lat), 64'(WAIT_STATES + 3));
        checkVal("fetch_rdata", 64'(if_rdata), 64'h0000_0000_DEAD_BEEF);
        if_req = 1'b0;

        // Single write: mem_we for WAIT_STATES+1 cycles, read data untouched.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'h12345678;
        lat      = 0;
        weCycles = 0;
        do begin
            stepCycle();
            lat++;
            if (dutMemWe) begin
                weCycles++;
            end
        end while (!dutDmAck && lat < 20);
        checkVal("write_latency", 64'(lat), 64'(WAIT_STATES + 3));
        checkVal("write_we_cycles", 64'(weCycles), 64'(WAIT_STATES + 1));
        checkVal("write_dm_rdata", 64'(dm_rdata), 64'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        stepCycle();

        for (int p = 0; p < 4; p++) begin
            ifPct  = phaseCfg[p][0];
            dmPct  = phaseCfg[p][1];
            rePct  = phaseCfg[p][2];
            wePct  = phaseCfg[p][3];
            rstPct = phaseCfg[p][4];
            for (int c = 0; c < 600; c++) begin
                driveRandom();
                stepCycle();
            end
        end

        rst    = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            stepCycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
